// File: rtl/mont_mul_issue_sched.sv
// rtl/mont_mul_issue_sched.sv - round-robin, credit-based issue of two requesters onto one pipelined Montgomery multiplier
module mont_mul_issue_sched #(
    parameter int DATA_W     = 256,
    parameter int LATENCY    = 4,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              ASYNC_RESET,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              mul_valid,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [DATA_W-1:0] mul_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_src,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + LATENCY + 2);

    // Stage 0 is the issue register; stage LATENCY lines up with mul_res.
    logic [LATENCY:0]    vld_q, vld_d;
    logic [LATENCY:0]    src_q, src_d;
    logic [TAG_W-1:0]    tag_q [0:LATENCY];
    logic [TAG_W-1:0]    tag_d [0:LATENCY];
    logic [DATA_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                rr_q, rr_d;

    logic [DATA_W-1:0]   fdata_q [0:FIFO_DEPTH-1];
    logic [DATA_W-1:0]   fdata_d [0:FIFO_DEPTH-1];
    logic [TAG_W-1:0]    ftag_q  [0:FIFO_DEPTH-1];
    logic [TAG_W-1:0]    ftag_d  [0:FIFO_DEPTH-1];
    logic [FIFO_DEPTH-1:0] fsrc_q, fsrc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [OCC_W-1:0]    occ;
    logic                can_issue, gnt0, gnt1, push, pop;

    // Every op in flight already owns a FIFO slot, so the pipeline never stalls.
    always_comb begin
        occ = OCC_W'(cnt_q);
        for (int i = 0; i <= LATENCY; i++) begin
            occ = occ + OCC_W'(vld_q[i]);
        end
    end

    assign can_issue = (occ < OCC_W'(FIFO_DEPTH));
    assign gnt0      = can_issue & req0_valid & (~req1_valid | ~rr_q);
    assign gnt1      = can_issue & req1_valid & (~req0_valid | rr_q);
    assign push      = vld_q[LATENCY];
    assign pop       = (cnt_q != '0) & rsp_ready;

    always_comb begin
        rr_d    = rr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (gnt0) begin
            rr_d    = 1'b1;
            mul_a_d = req0_a;
            mul_b_d = req0_b;
        end else if (gnt1) begin
            rr_d    = 1'b0;
            mul_a_d = req1_a;
            mul_b_d = req1_b;
        end

        vld_d[0] = gnt0 | gnt1;
        src_d[0] = gnt1;
        tag_d[0] = gnt1 ? req1_tag : req0_tag;
        for (int i = 1; i <= LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            src_d[i] = src_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        fdata_d  = fdata_q;
        ftag_d   = ftag_q;
        fsrc_d   = fsrc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fdata_d[wr_ptr_q] = mul_res;
            ftag_d[wr_ptr_q]  = tag_q[LATENCY];
            fsrc_d[wr_ptr_q]  = src_q[LATENCY];
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RESET) begin
        if (!ASYNC_RESET) begin
            vld_q    <= '0;
            src_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            rr_q     <= 1'b0;
            fsrc_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fdata_q[i] <= '0;
                ftag_q[i]  <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            src_q    <= src_d;
            tag_q    <= tag_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            rr_q     <= rr_d;
            fdata_q  <= fdata_d;
            ftag_q   <= ftag_d;
            fsrc_q   <= fsrc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign mul_valid  = vld_q[0];
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp_valid  = (cnt_q != '0);
    assign rsp_data   = fdata_q[rd_ptr_q];
    assign rsp_tag    = ftag_q[rd_ptr_q];
    assign rsp_src    = fsrc_q[rd_ptr_q];
    assign busy       = (occ != '0);

endmodule
